bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single memory port between instruction fetch (m0) and the load store unit (m1).
- Sits between the core's fetch/LSU bus masters and the memory/peripheral interconnect.
- Holds a grant for the full CYC of the granted master.
- Selects between masters by fixed priority or round-robin.
- A bus watchdog keeps the core from hanging on an unresponsive slave.

Parameters:
- XLEN, 32: address/data width of all three Wishbone ports.
- FAIR, 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, m1 (LSU) wins.
- TIMEOUT, 255: cycles a granted STB may wait without ACK before the watchdog fires; must be ≥ 1, counter width = $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- m0  wishbone.SLAVE  iface(XLEN)  instruction-fetch master side: ADR, DAT_W, WE, STB, CYC in; DAT_R, ACK out.
- m1  wishbone.SLAVE  iface(XLEN)  LSU master side, same fields.
- s  wishbone.MASTER  iface(XLEN)  shared slave side: ADR, DAT_W, WE, STB, CYC out; DAT_R, ACK in.
- timeout_clr  input  1  synchronous clear of timeout_flag.
- timeout_flag  output  1  sticky; set when the watchdog fires.
- grant  output  2  one-hot current owner: {m1, m0}; 2'b00 when idle.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - state = IDLE; grant = 0; watchdog counter = 0; timeout_flag = 0.
  - last_grant = m1, so the first tie goes to m0.
  - s.CYC/STB/WE = 0, s.ADR/DAT_W = 0; m0.ACK = m1.ACK = 0.
- States: IDLE, GNT0, GNT1 (registered; grant output = state decode).
- IDLE:
  - Slave outputs driven 0.
  - A requester is any master with CYC = 1.
  - Neither requests -> stay IDLE.
  - One requests -> go to its GNT state next edge.
  - Both request -> FAIR=1: grant the master opposite last_grant; FAIR=0: GNT1.
- Arbitration latency: a master raising CYC in IDLE sees its STB on s one cycle later. Grant is never given combinationally.
- GNTx:
  - s.ADR/DAT_W/WE/STB/CYC = mx's signals.
  - s.DAT_R is broadcast to both masters.
  - s.ACK is routed to mx.ACK only; the other master's ACK = 0.
  - The grant is held while mx.CYC = 1. Multiple STB/ACK beats within one CYC stay with mx.
  - The non-granted master's requests are ignored and not acknowledged; it waits.
- Release: on the edge where mx.CYC = 0 in GNTx, last_grant <= x and the next state is chosen by the IDLE rules on current requests.
  - The other master requesting -> direct handover to its GNT state, no idle cycle.
  - mx itself re-raises CYC in the same cycle -> FAIR=1 favours the other master if it is requesting.
- Watchdog:
  - In GNTx the counter increments each cycle with s.STB = 1 and s.ACK = 0.
  - It clears on ACK, on STB = 0, and on leaving GNTx.
  - When the counter reaches TIMEOUT:
    - That cycle, mx.ACK is forced 1 with mx.DAT_R = 0.
    - s.CYC/STB are forced 0.
    - timeout_flag <= 1.
    - Next state = IDLE (last_grant <= x), counter <= 0.
  - A real s.ACK in the same cycle the counter reaches TIMEOUT wins: it is a normal ACK, no timeout.
- timeout_flag:
  - Stays set until timeout_clr = 1.
  - When set and clear coincide, set wins.
- Write/read are transparent; the arbiter never alters ADR, DAT_W or WE.

Test Plan:
- Single m0 read: m0 CYC/STB, ADR=0x100 at t0; slave ACKs at t2 with DAT_R=0xDEADBEEF -> s.STB first high at t1, m0.ACK=1 and m0.DAT_R=0xDEADBEEF at t2, m1.ACK=0, grant=01 then 00.
- Simultaneous request after reset, FAIR=1: m0 and m1 both raise CYC at t0 -> GNT0 first. After m0 drops CYC, handover directly to GNT1 with no IDLE cycle. A second tie then goes to m0.
- FAIR=0 tie: both request repeatedly -> m1 granted every tie; m0 only granted when m1.CYC=0.
- Grant hold: m1 holds CYC over two beats (STB/ACK twice, ADR 0x200, 0x204) while m0 requests -> m0 never sees ACK until m1 drops CYC; s.ADR follows m1 only.
- Watchdog, TIMEOUT=4: m0 STB with slave never ACKing -> on the 4th waiting cycle m0.ACK=1, m0.DAT_R=0, s.CYC=0, timeout_flag=1. Flag stays set until a timeout_clr pulse. ACK arriving exactly at count 4 -> normal ACK, flag stays 0.
- Reset mid-transfer: rst_n low while in GNT1 with STB pending -> s.CYC/STB=0, grant=00, m1.ACK=0 immediately (asynchronous). After release, a tie grants m0 first.

Source files
------------

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Two-master, one-slave Wishbone arbiter. Instruction fetch (m0) and the
// load/store unit (m1) share a single memory port (s). Once a master is
// granted, it keeps the grant for the whole of its CYC. Simultaneous
// requests are resolved by round-robin (FAIR=1) or by fixed priority with
// m1 winning (FAIR=0). A watchdog terminates any strobe that the slave
// leaves unacknowledged for TIMEOUT cycles. It returns a dummy ACK with
// zero data so that the core cannot hang.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   m0_*_i / m0_*_o  fetch master side   (adr, dat_w, we, stb, cyc in;
//                                         dat_r, ack out)
//   m1_*_i / m1_*_o  LSU master side     (same fields)
//   s_*_o / s_*_i    shared slave side   (adr, dat_w, we, stb, cyc out;
//                                         dat_r, ack in)
//   timeout_clr    synchronous clear of timeout_flag
//   timeout_flag   sticky indication that the watchdog has fired
//   grant          one-hot current owner {m1, m0}, 2'b00 when idle
// ---------------------------------------------------------------------------
module bus_arbiter #(
   parameter int XLEN    = 32,
   parameter int FAIR    = 1,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic [XLEN-1:0] m0_adr_i,
   input  logic [XLEN-1:0] m0_dat_w_i,
   input  logic            m0_we_i,
   input  logic            m0_stb_i,
   input  logic            m0_cyc_i,
   output logic [XLEN-1:0] m0_dat_r_o,
   output logic            m0_ack_o,

   input  logic [XLEN-1:0] m1_adr_i,
   input  logic [XLEN-1:0] m1_dat_w_i,
   input  logic            m1_we_i,
   input  logic            m1_stb_i,
   input  logic            m1_cyc_i,
   output logic [XLEN-1:0] m1_dat_r_o,
   output logic            m1_ack_o,

   output logic [XLEN-1:0] s_adr_o,
   output logic [XLEN-1:0] s_dat_w_o,
   output logic            s_we_o,
   output logic            s_stb_o,
   output logic            s_cyc_o,
   input  logic [XLEN-1:0] s_dat_r_i,
   input  logic            s_ack_i,

   input  logic            timeout_clr,
   output logic            timeout_flag,
   output logic [1:0]      grant
);

   // The watchdog counter only ever needs to reach TIMEOUT-1. It fires
   // during the cycle that would take it to TIMEOUT.
   localparam int            CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            lastGrant_q, lastGrant_d;     // 1 = m1 owned the bus last
   logic [CW-1:0]   wdCount_q, wdCount_d;
   logic            timeoutFlag_q, timeoutFlag_d;

   logic            granted;
   logic            ownerIsM1;
   logic [XLEN-1:0] ownAdr;
   logic [XLEN-1:0] ownDatW;
   logic            ownWe;
   logic            ownStb;
   logic            ownCyc;
   logic            waiting;
   logic            wdFire;

   // Arbitration decision used both from IDLE and at the release of a grant.
   // lastWasM1 is the most recent owner. Under round-robin, the other master
   // wins a tie. Under fixed priority, the LSU always wins a tie.
   function automatic state_e pickNext(input logic req0,
                                       input logic req1,
                                       input logic lastWasM1);
      state_e nxt;
      nxt = IDLE;
      if (req0 && req1) begin
         if (FAIR != 0) begin
            nxt = lastWasM1 ? GNT0 : GNT1;
         end else begin
            nxt = GNT1;
         end
      end else if (req0) begin
         nxt = GNT0;
      end else if (req1) begin
         nxt = GNT1;
      end
      return nxt;
   endfunction

   // Select the bus signals of the current owner. Outside a grant these
   // values are never used, because the slave outputs are gated by
   // 'granted' below.
   always_comb begin
      granted   = (state_q == GNT0) || (state_q == GNT1);
      ownerIsM1 = (state_q == GNT1);
      ownAdr    = m0_adr_i;
      ownDatW   = m0_dat_w_i;
      ownWe     = m0_we_i;
      ownStb    = m0_stb_i;
      ownCyc    = m0_cyc_i;
      if (ownerIsM1) begin
         ownAdr  = m1_adr_i;
         ownDatW = m1_dat_w_i;
         ownWe   = m1_we_i;
         ownStb  = m1_stb_i;
         ownCyc  = m1_cyc_i;
      end
   end

   // A strobe is waiting when the owner is mid-cycle with STB up and the
   // slave has not answered. The watchdog fires on the waiting cycle that
   // brings the count to TIMEOUT. A genuine ACK in that same cycle keeps
   // 'waiting' low, so the real ACK takes precedence.
   always_comb begin
      waiting = granted && ownCyc && ownStb && !s_ack_i;
      wdFire  = waiting && (wdCount_q == WD_LAST);
   end

   // Bus steering. The slave sees only the owner's signals, and all zero
   // while idle. Read data is broadcast to both masters, except on a
   // watchdog abort, where it is zeroed. ACK goes only to the owner. On an
   // abort, CYC and STB are pulled low so that the slave can drop the stuck
   // transfer.
   always_comb begin
      s_adr_o    = '0;
      s_dat_w_o  = '0;
      s_we_o     = 1'b0;
      s_stb_o    = 1'b0;
      s_cyc_o    = 1'b0;
      m0_dat_r_o = s_dat_r_i;
      m1_dat_r_o = s_dat_r_i;
      m0_ack_o   = 1'b0;
      m1_ack_o   = 1'b0;
      if (granted) begin
         s_adr_o   = ownAdr;
         s_dat_w_o = ownDatW;
         s_we_o    = ownWe;
         s_stb_o   = ownStb;
         s_cyc_o   = ownCyc;
         if (wdFire) begin
            s_stb_o    = 1'b0;
            s_cyc_o    = 1'b0;
            m0_dat_r_o = '0;
            m1_dat_r_o = '0;
         end
         if (ownerIsM1) begin
            m1_ack_o = s_ack_i || wdFire;
         end else begin
            m0_ack_o = s_ack_i || wdFire;
         end
      end
   end

   // Next-state logic. The counter defaults to zero. It advances only while
   // the same owner keeps waiting. Therefore ACK, a dropped STB, a release
   // and an abort all clear it. The sticky flag gives priority to a set
   // over a coincident clear.
   always_comb begin
      state_d       = state_q;
      lastGrant_d   = lastGrant_q;
      wdCount_d     = '0;
      timeoutFlag_d = timeoutFlag_q;

      if (timeout_clr) begin
         timeoutFlag_d = 1'b0;
      end
      if (wdFire) begin
         timeoutFlag_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            state_d = pickNext(m0_cyc_i, m1_cyc_i, lastGrant_q);
         end
         GNT0, GNT1: begin
            if (wdFire) begin
               state_d     = IDLE;
               lastGrant_d = ownerIsM1;
            end else if (!ownCyc) begin
               // A release hands the bus straight to a waiting master,
               // with no idle cycle between the two grants.
               lastGrant_d = ownerIsM1;
               state_d     = pickNext(m0_cyc_i, m1_cyc_i, ownerIsM1);
            end else if (waiting) begin
               wdCount_d = wdCount_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset forces IDLE at once. Because every bus output
   // is decoded from the state, this also drops CYC, STB and ACK in the
   // middle of a transfer. After reset, m1 counts as the last owner, so the
   // first tie goes to instruction fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lastGrant_q   <= 1'b1;
         wdCount_q     <= '0;
         timeoutFlag_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lastGrant_q   <= lastGrant_d;
         wdCount_q     <= wdCount_d;
         timeoutFlag_q <= timeoutFlag_d;
      end
   end

   assign grant        = {state_q == GNT1, state_q == GNT0};
   assign timeout_flag = timeoutFlag_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter. The main instance uses round-robin with a
// short watchdog. A second instance, driven by the same inputs, uses fixed
// priority. Expected master responses are queued when the stimulus is
// issued. A monitor process pops and compares them whenever the main
// instance raises an ACK.
module tb_bus_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;

   logic [XLEN-1:0] m0Adr, m0DatW, m1Adr, m1DatW, sDatR;
   logic            m0We, m0Stb, m0Cyc, m1We, m1Stb, m1Cyc, sAck, timeoutClr;

   logic [XLEN-1:0] m0DatR, m1DatR, sAdr, sDatW;
   logic            m0Ack, m1Ack, sWe, sStb, sCyc, timeoutFlag;
   logic [1:0]      grant;

   logic [XLEN-1:0] fxM0DatR, fxM1DatR, fxSAdr, fxSDatW;
   logic            fxM0Ack, fxM1Ack, fxSWe, fxSStb, fxSCyc, fxFlag;
   logic [1:0]      fxGrant;

   typedef struct packed {
      logic            who;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.XLEN(XLEN), .FAIR(1), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0Adr), .m0_dat_w_i(m0DatW), .m0_we_i(m0We), .m0_stb_i(m0Stb),
      .m0_cyc_i(m0Cyc), .m0_dat_r_o(m0DatR), .m0_ack_o(m0Ack),
      .m1_adr_i(m1Adr), .m1_dat_w_i(m1DatW), .m1_we_i(m1We), .m1_stb_i(m1Stb),
      .m1_cyc_i(m1Cyc), .m1_dat_r_o(m1DatR), .m1_ack_o(m1Ack),
      .s_adr_o(sAdr), .s_dat_w_o(sDatW), .s_we_o(sWe), .s_stb_o(sStb),
      .s_cyc_o(sCyc), .s_dat_r_i(sDatR), .s_ack_i(sAck),
      .timeout_clr(timeoutClr), .timeout_flag(timeoutFlag), .grant(grant)
   );

   bus_arbiter #(.XLEN(XLEN), .FAIR(0), .TIMEOUT(4)) dutFixed (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0Adr), .m0_dat_w_i(m0DatW), .m0_we_i(m0We), .m0_stb_i(m0Stb),
      .m0_cyc_i(m0Cyc), .m0_dat_r_o(fxM0DatR), .m0_ack_o(fxM0Ack),
      .m1_adr_i(m1Adr), .m1_dat_w_i(m1DatW), .m1_we_i(m1We), .m1_stb_i(m1Stb),
      .m1_cyc_i(m1Cyc), .m1_dat_r_o(fxM1DatR), .m1_ack_o(fxM1Ack),
      .s_adr_o(fxSAdr), .s_dat_w_o(fxSDatW), .s_we_o(fxSWe), .s_stb_o(fxSStb),
      .s_cyc_o(fxSCyc), .s_dat_r_i(sDatR), .s_ack_i(sAck),
      .timeout_clr(timeoutClr), .timeout_flag(fxFlag), .grant(fxGrant)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of stimulus just after the rising edge
   task automatic applyStimulus(input logic c0, input logic s0, input logic [31:0] a0,
                                input logic c1, input logic s1, input logic [31:0] a1,
                                input logic ack, input logic [31:0] dat);
      @(posedge clk);
      #1;
      m0Cyc = c0; m0Stb = s0; m0Adr = a0; m0DatW = ~a0; m0We = 1'b0;
      m1Cyc = c1; m1Stb = s1; m1Adr = a1; m1DatW = ~a1; m1We = 1'b1;
      sAck  = ack; sDatR = dat;
      timeoutClr = 1'b0;
   endtask

   task automatic pushExpect(input logic who, input logic [31:0] data);
      exp_t e;
      e.who  = who;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
   endtask

   // Monitor: every ACK the main instance presents must match the oldest
   // expected response, including which master got it and the data it saw
   initial begin : monitor
      exp_t e;
      logic [31:0] seen;
      forever begin
         @(negedge clk);
         if (m0Ack || m1Ack) begin
            if (expQ.size() == 0) begin
               checkOutput("ack with empty scoreboard", {m1Ack, m0Ack}, 32'h0);
            end else begin
               e = expQ.pop_front();
               seen = m1Ack ? m1DatR : m0DatR;
               checkOutput("ack owner", {m1Ack, m0Ack}, e.who ? 32'h2 : 32'h1);
               checkOutput("ack data", seen, e.data);
            end
         end
      end
   end

   initial begin : stimulus
      m0Cyc = 0; m0Stb = 0; m0Adr = 0; m0DatW = 0; m0We = 0;
      m1Cyc = 0; m1Stb = 0; m1Adr = 0; m1DatW = 0; m1We = 0;
      sAck = 0; sDatR = 0; timeoutClr = 0;

      // Reset values
      #2 rst_n = 1'b0;
      #2;
      checkOutput("reset grant", 32'(grant), 32'h0);
      checkOutput("reset s_cyc", 32'(sCyc), 32'h0);
      checkOutput("reset s_stb", 32'(sStb), 32'h0);
      checkOutput("reset s_adr", sAdr, 32'h0);
      checkOutput("reset acks", {m1Ack, m0Ack}, 32'h0);
      checkOutput("reset flag", 32'(timeoutFlag), 32'h0);
      #18 rst_n = 1'b1;

      // Single m0 read
      applyStimulus(1, 1, 32'h100, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("t0 grant", 32'(grant), 32'h0);
      checkOutput("t0 s_stb", 32'(sStb), 32'h0);
      applyStimulus(1, 1, 32'h100, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("t1 grant", 32'(grant), 32'h1);
      checkOutput("t1 s_stb", 32'(sStb), 32'h1);
      checkOutput("t1 s_cyc", 32'(sCyc), 32'h1);
      checkOutput("t1 s_adr", sAdr, 32'h100);
      checkOutput("t1 s_dat_w", sDatW, ~32'h100);
      checkOutput("t1 s_we", 32'(sWe), 32'h0);
      applyStimulus(1, 1, 32'h100, 0, 0, 32'h0, 1, 32'hDEADBEEF);
      pushExpect(0, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("t2 m1 ack", 32'(m1Ack), 32'h0);
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("release grant", 32'(grant), 32'h1);
      idleCycle();
      @(negedge clk);
      checkOutput("idle grant", 32'(grant), 32'h0);

      // Tie after reset goes to m0, then direct handover to m1
      @(negedge clk); #1 rst_n = 1'b0; #2 rst_n = 1'b1;
      applyStimulus(1, 1, 32'h10, 1, 1, 32'h20, 0, 32'h0);
      @(negedge clk);
      checkOutput("tie idle grant", 32'(grant), 32'h0);
      applyStimulus(1, 1, 32'h10, 1, 1, 32'h20, 1, 32'h11111111);
      pushExpect(0, 32'h11111111);
      @(negedge clk);
      checkOutput("tie first owner", 32'(grant), 32'h1);
      checkOutput("tie s_adr m0", sAdr, 32'h10);
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h20, 0, 32'h0);
      @(negedge clk);
      checkOutput("handover release", 32'(grant), 32'h1);
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h20, 1, 32'h22222222);
      pushExpect(1, 32'h22222222);
      @(negedge clk);
      checkOutput("handover no idle", 32'(grant), 32'h2);
      checkOutput("handover s_adr m1", sAdr, 32'h20);
      idleCycle();
      @(negedge clk);
      checkOutput("m1 release", 32'(grant), 32'h2);
      applyStimulus(1, 1, 32'h30, 1, 1, 32'h40, 0, 32'h0);
      @(negedge clk);
      checkOutput("second tie idle", 32'(grant), 32'h0);
      applyStimulus(1, 1, 32'h30, 1, 1, 32'h40, 0, 32'h0);
      @(negedge clk);
      checkOutput("second tie to m0", 32'(grant), 32'h1);
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h40, 0, 32'h0);
      @(negedge clk);
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h40, 1, 32'h44444444);
      pushExpect(1, 32'h44444444);
      @(negedge clk);
      checkOutput("m1 after m0", 32'(grant), 32'h2);
      idleCycle();
      idleCycle();
      @(negedge clk);
      checkOutput("idle after ties", 32'(grant), 32'h0);

      // Fixed priority: m1 wins every tie (CYC only, no strobes)
      applyStimulus(1, 0, 32'h50, 1, 0, 32'h60, 0, 32'h77);
      @(negedge clk);
      checkOutput("fixed idle", 32'(fxGrant), 32'h0);
      applyStimulus(1, 0, 32'h50, 1, 0, 32'h60, 0, 32'h77);
      @(negedge clk);
      checkOutput("fixed tie 1", 32'(fxGrant), 32'h2);
      checkOutput("fair tie differs", 32'(grant), 32'h1);
      checkOutput("fixed s_adr", fxSAdr, 32'h60);
      checkOutput("fixed s_dat_w", fxSDatW, ~32'h60);
      checkOutput("fixed s_we", 32'(fxSWe), 32'h1);
      checkOutput("fixed s_cyc", 32'(fxSCyc), 32'h1);
      checkOutput("fixed s_stb", 32'(fxSStb), 32'h0);
      checkOutput("fixed dat_r m0", fxM0DatR, 32'h77);
      checkOutput("fixed dat_r m1", fxM1DatR, 32'h77);
      checkOutput("fixed acks", {fxM1Ack, fxM0Ack}, 32'h0);
      checkOutput("fixed flag", 32'(fxFlag), 32'h0);
      idleCycle();
      @(negedge clk);
      applyStimulus(1, 0, 32'h50, 1, 0, 32'h60, 0, 32'h0);
      @(negedge clk);
      checkOutput("fixed idle 2", 32'(fxGrant), 32'h0);
      applyStimulus(1, 0, 32'h50, 1, 0, 32'h60, 0, 32'h0);
      @(negedge clk);
      checkOutput("fixed tie 2", 32'(fxGrant), 32'h2);
      checkOutput("fair tie alternates", 32'(grant), 32'h2);
      applyStimulus(1, 0, 32'h50, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("fixed m1 release", 32'(fxGrant), 32'h2);
      applyStimulus(1, 0, 32'h50, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("fixed m0 alone", 32'(fxGrant), 32'h1);
      idleCycle();
      idleCycle();
      @(negedge clk);
      checkOutput("fixed back idle", 32'(fxGrant), 32'h0);

      // Grant hold: m1 does two beats while m0 waits
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h200, 0, 32'h0);
      @(negedge clk);
      applyStimulus(1, 1, 32'h300, 1, 1, 32'h200, 1, 32'hA0A0A0A0);
      pushExpect(1, 32'hA0A0A0A0);
      @(negedge clk);
      checkOutput("hold beat1 grant", 32'(grant), 32'h2);
      checkOutput("hold beat1 adr", sAdr, 32'h200);
      applyStimulus(1, 1, 32'h300, 1, 1, 32'h204, 1, 32'hB0B0B0B0);
      pushExpect(1, 32'hB0B0B0B0);
      @(negedge clk);
      checkOutput("hold beat2 grant", 32'(grant), 32'h2);
      checkOutput("hold beat2 adr", sAdr, 32'h204);
      applyStimulus(1, 1, 32'h300, 0, 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      checkOutput("hold m0 waits", 32'(m0Ack), 32'h0);
      applyStimulus(1, 1, 32'h300, 0, 0, 32'h0, 1, 32'hC0C0C0C0);
      pushExpect(0, 32'hC0C0C0C0);
      @(negedge clk);
      checkOutput("hold m0 granted", 32'(grant), 32'h1);
      checkOutput("hold m0 adr", sAdr, 32'h300);
      idleCycle();
      idleCycle();

      // Watchdog fires on the 4th waiting cycle; set beats a coincident clear
      applyStimulus(1, 1, 32'h400, 0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 32'h400, 0, 0, 32'h0, 0, 32'h0);
         @(negedge clk);
         checkOutput("wd waiting s_cyc", 32'(sCyc), 32'h1);
      end
      applyStimulus(1, 1, 32'h400, 0, 0, 32'h0, 0, 32'h55555555);
      timeoutClr = 1'b1;
      pushExpect(0, 32'h0);
      @(negedge clk);
      checkOutput("wd fire s_cyc", 32'(sCyc), 32'h0);
      checkOutput("wd fire s_stb", 32'(sStb), 32'h0);
      checkOutput("wd flag not yet", 32'(timeoutFlag), 32'h0);
      idleCycle();
      @(negedge clk);
      checkOutput("wd flag set", 32'(timeoutFlag), 32'h1);
      checkOutput("wd back idle", 32'(grant), 32'h0);
      idleCycle();
      timeoutClr = 1'b1;
      @(negedge clk);
      checkOutput("wd flag sticky", 32'(timeoutFlag), 32'h1);
      idleCycle();
      @(negedge clk);
      checkOutput("wd flag cleared", 32'(timeoutFlag), 32'h0);

      // Real ACK exactly at the timeout count wins
      applyStimulus(1, 1, 32'h500, 0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 32'h500, 0, 0, 32'h0, 0, 32'h0);
      end
      applyStimulus(1, 1, 32'h500, 0, 0, 32'h0, 1, 32'h12345678);
      pushExpect(0, 32'h12345678);
      @(negedge clk);
      checkOutput("late ack s_cyc", 32'(sCyc), 32'h1);
      idleCycle();
      @(negedge clk);
      checkOutput("late ack no flag", 32'(timeoutFlag), 32'h0);
      idleCycle();

      // Asynchronous reset in the middle of an m1 transfer
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h600, 0, 32'h0);
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h600, 0, 32'h0);
      #1;
      checkOutput("pre-reset grant", 32'(grant), 32'h2);
      rst_n = 1'b0;
      sAck  = 1'b1;
      sDatR = 32'h66;
      #1;
      checkOutput("async reset grant", 32'(grant), 32'h0);
      checkOutput("async reset s_cyc", 32'(sCyc), 32'h0);
      checkOutput("async reset s_stb", 32'(sStb), 32'h0);
      checkOutput("async reset m1 ack", 32'(m1Ack), 32'h0);
      @(negedge clk);
      m1Cyc = 0; m1Stb = 0; sAck = 0;
      #2 rst_n = 1'b1;
      applyStimulus(1, 1, 32'h700, 1, 1, 32'h800, 0, 32'h0);
      @(negedge clk);
      checkOutput("post-reset idle", 32'(grant), 32'h0);
      applyStimulus(1, 1, 32'h700, 1, 1, 32'h800, 0, 32'h0);
      @(negedge clk);
      checkOutput("post-reset tie to m0", 32'(grant), 32'h1);
      idleCycle();
      idleCycle();
      @(negedge clk);

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
